// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl: frame-ticked player walk, knockback, invulnerability and wall clamping
module char_motion_ctrl #(
  parameter logic [9:0] X_START    = 10'd320,
  parameter logic [9:0] Y_START    = 10'd240,
  parameter logic [9:0] X_MIN      = 10'd32,
  parameter logic [9:0] X_MAX      = 10'd592,
  parameter logic [9:0] Y_MIN      = 10'd32,
  parameter logic [9:0] Y_MAX      = 10'd432,
  parameter logic [9:0] STEP       = 10'd2,
  parameter logic [9:0] KB_STEP    = 10'd4,
  parameter logic [3:0] KB_FRAMES  = 4'd8,
  parameter logic [5:0] INV_FRAMES = 6'd60
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [15:0] keycode,
  input  logic        enable,
  input  logic        soft_reset,
  input  logic        hit,
  output logic [9:0]  Char_X,
  output logic [9:0]  Char_Y,
  output logic [1:0]  facing,
  output logic        moving,
  output logic        invulnerable,
  output logic        blink,
  output logic        key_valid
);
  typedef enum logic [1:0] {IDLE, WALK, KNOCK} state_t;
  localparam logic signed [10:0] ST = signed'({1'b0, STEP});
  localparam logic signed [10:0] KS = signed'({1'b0, KB_STEP});
  state_t state, state_n;
  logic f1, f2, f3, tick;
  logic up, dn, lf, rt, dxp, dxn, dyp, dyn, hit_ok, moving_n;
  logic signed [10:0] sx, sy;
  logic [9:0] x_n, y_n;
  logic [1:0] facing_n;
  logic [3:0] kb_cnt, kb_n;
  logic [5:0] inv_cnt, inv_n;

  function automatic logic [9:0] clamp(input logic signed [10:0] v, input logic [9:0] lo, input logic [9:0] hi);
    return v < signed'({1'b0, lo}) ? lo : v > signed'({1'b0, hi}) ? hi : v[9:0];
  endfunction

  // frame_clk is asynchronous: two flops for metastability, third for edge detect
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) {f1, f2, f3, tick} <= '0;
    else begin
      f1 <= frame_clk;
      f2 <= f1;
      f3 <= f2;
      tick <= f2 & ~f3;
    end

  assign up = keycode[7:0] == 8'h1A || keycode[15:8] == 8'h1A;
  assign dn = keycode[7:0] == 8'h16 || keycode[15:8] == 8'h16;
  assign lf = keycode[7:0] == 8'h04 || keycode[15:8] == 8'h04;
  assign rt = keycode[7:0] == 8'h07 || keycode[15:8] == 8'h07;
  assign key_valid = up | dn | lf | rt;
  assign dxp = rt & ~lf;
  assign dxn = lf & ~rt;
  assign dyp = dn & ~up;
  assign dyn = up & ~dn;
  assign hit_ok = enable & hit & ~invulnerable & (state != KNOCK);
  assign invulnerable = inv_cnt != 6'd0;
  assign blink = invulnerable & inv_cnt[2];

  always_comb begin
    state_n = state;
    facing_n = facing;
    kb_n = kb_cnt;
    inv_n = inv_cnt;
    sx = '0;
    sy = '0;
    if (enable) begin
      if (state != KNOCK) begin
        state_n = (dxp | dxn | dyp | dyn) ? WALK : IDLE;
        facing_n = dxp ? 2'd3 : dxn ? 2'd2 : dyp ? 2'd1 : dyn ? 2'd0 : facing;
        if (tick && state == WALK) begin
          sx = dxp ? ST : dxn ? -ST : '0;
          sy = dyp ? ST : dyn ? -ST : '0;
        end
      end else if (tick) begin
        sx = facing == 2'd2 ? KS : facing == 2'd3 ? -KS : '0;
        sy = facing == 2'd0 ? KS : facing == 2'd1 ? -KS : '0;
        kb_n = kb_cnt - 4'd1;
        state_n = kb_cnt <= 4'd1 ? IDLE : KNOCK;
      end
      if (tick && invulnerable) inv_n = inv_cnt - 6'd1;
      if (hit_ok) begin
        state_n = KNOCK;
        kb_n = KB_FRAMES;
        inv_n = INV_FRAMES;
      end
    end
    x_n = clamp(signed'({1'b0, Char_X}) + sx, X_MIN, X_MAX);
    y_n = clamp(signed'({1'b0, Char_Y}) + sy, Y_MIN, Y_MAX);
    moving_n = enable & (state_n == WALK);
    if (soft_reset) begin
      state_n = IDLE;
      facing_n = 2'd1;
      kb_n = '0;
      inv_n = '0;
      x_n = X_START;
      y_n = Y_START;
      moving_n = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      Char_X <= X_START;
      Char_Y <= Y_START;
      facing <= 2'd1;
      kb_cnt <= '0;
      inv_cnt <= '0;
      moving <= 1'b0;
    end else begin
      state <= state_n;
      Char_X <= x_n;
      Char_Y <= y_n;
      facing <= facing_n;
      kb_cnt <= kb_n;
      inv_cnt <= inv_n;
      moving <= moving_n;
    end
endmodule

// File: tb/tb_char_motion_ctrl.sv
// tb_char_motion_ctrl: directed walk, clamp, knockback, invulnerability and respawn checks
module tb_char_motion_ctrl;
  logic Clk = 0, Reset_n = 0, frame_clk = 0, enable = 0, soft_reset = 0, hit = 0;
  logic [15:0] keycode = '0;
  logic [9:0] Char_X, Char_Y;
  logic [1:0] facing;
  logic moving, invulnerable, blink, key_valid;
  int checks = 0, errors = 0;

  char_motion_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .enable(enable), .soft_reset(soft_reset), .hit(hit),
    .Char_X(Char_X), .Char_Y(Char_Y), .facing(facing), .moving(moving),
    .invulnerable(invulnerable), .blink(blink), .key_valid(key_valid)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_clk = 1;
      repeat (6) @(negedge Clk);
      frame_clk = 0;
      repeat (6) @(negedge Clk);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_hit();
    hit = 1;
    @(negedge Clk);
    hit = 0;
    @(negedge Clk);
  endtask

  initial begin
    clks(3);
    chk("rst_x", Char_X, 320);
    chk("rst_y", Char_Y, 240);
    chk("rst_facing", facing, 1);
    chk("rst_moving", moving, 0);
    chk("rst_inv", invulnerable, 0);
    chk("rst_blink", blink, 0);
    Reset_n = 1;
    enable = 1;
    clks(2);
    keycode = 16'h0007;
    clks(2);
    ticks(10);
    chk("walk_r_x", Char_X, 340);
    chk("walk_r_facing", facing, 3);
    chk("walk_r_moving", moving, 1);
    chk("walk_r_keyvalid", key_valid, 1);
    keycode = 16'h0000;
    clks(2);
    chk("idle_moving", moving, 0);
    ticks(2);
    chk("idle_x", Char_X, 340);
    keycode = 16'h0007;
    clks(2);
    ticks(2);
    chk("walk_more_x", Char_X, 344);
    #2 Reset_n = 0;
    #1;
    chk("async_rst_x", Char_X, 320);
    chk("async_rst_y", Char_Y, 240);
    chk("async_rst_facing", facing, 1);
    chk("async_rst_moving", moving, 0);
    keycode = 16'h0000;
    clks(1);
    ticks(3);
    chk("rst_hold_x", Char_X, 320);
    chk("rst_hold_y", Char_Y, 240);
    Reset_n = 1;
    clks(2);
    keycode = 16'h1A04;
    clks(2);
    ticks(102);
    keycode = 16'h0004;
    clks(2);
    ticks(38);
    chk("pre_corner_x", Char_X, 40);
    chk("pre_corner_y", Char_Y, 36);
    keycode = 16'h1A04;
    clks(2);
    ticks(2);
    chk("corner2_x", Char_X, 36);
    chk("corner2_y", Char_Y, 32);
    ticks(3);
    chk("corner_x", Char_X, 32);
    chk("corner_y", Char_Y, 32);
    chk("corner_facing", facing, 2);
    keycode = 16'h0704;
    clks(2);
    chk("cancel_keyvalid", key_valid, 1);
    chk("cancel_moving", moving, 0);
    ticks(2);
    chk("cancel_x", Char_X, 32);
    keycode = 16'h0007;
    clks(2);
    ticks(134);
    chk("to300_x", Char_X, 300);
    keycode = 16'h0000;
    clks(2);
    chk("to300_facing", facing, 3);
    pulse_hit();
    keycode = 16'h0004;
    chk("hit_inv", invulnerable, 1);
    chk("hit_blink", blink, 1);
    ticks(7);
    chk("kb7_x", Char_X, 272);
    chk("kb7_facing", facing, 3);
    chk("kb7_moving", moving, 0);
    ticks(1);
    chk("kb8_x", Char_X, 268);
    chk("kb8_blink", blink, 1);
    keycode = 16'h0000;
    clks(2);
    ticks(12);
    chk("t20_blink", blink, 0);
    pulse_hit();
    ticks(1);
    chk("rehit_x", Char_X, 268);
    chk("rehit_inv", invulnerable, 1);
    ticks(3);
    chk("t24_blink", blink, 1);
    ticks(35);
    chk("t59_inv", invulnerable, 1);
    ticks(1);
    chk("t60_inv", invulnerable, 0);
    chk("t60_blink", blink, 0);
    hit = 1;
    soft_reset = 1;
    @(negedge Clk);
    hit = 0;
    soft_reset = 0;
    chk("sr_x", Char_X, 320);
    chk("sr_y", Char_Y, 240);
    chk("sr_inv", invulnerable, 0);
    chk("sr_facing", facing, 1);
    ticks(1);
    chk("sr_tick_x", Char_X, 320);
    enable = 0;
    keycode = 16'h0016;
    clks(2);
    chk("dis_keyvalid", key_valid, 1);
    pulse_hit();
    ticks(5);
    chk("dis_y", Char_Y, 240);
    chk("dis_moving", moving, 0);
    chk("dis_inv", invulnerable, 0);
    enable = 1;
    clks(2);
    ticks(1);
    chk("en_y", Char_Y, 242);
    chk("en_facing", facing, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
